// File: rtl/sw_pkg.sv
// ---------------------------------------------------------------------------
// sw_pkg
// Shared definitions for the switch/button debouncer:
//   - db_state_t : per-channel debounce FSM states
//   - SYS_CLK_HZ : board system clock frequency (EGO1, 100 MHz)
//   - DB_MS      : default debounce window in milliseconds
//   - TICK_DIV_1MS : clock cycles in one 1 ms sample tick at SYS_CLK_HZ
// ---------------------------------------------------------------------------
package sw_pkg;

    typedef enum logic [1:0] {
        S_LO      = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HI      = 2'd2,
        S_WAIT_LO = 2'd3
    } db_state_t;

    localparam int SYS_CLK_HZ   = 100_000_000;
    localparam int DB_MS        = 20;
    localparam int TICK_DIV_1MS = SYS_CLK_HZ / 1000;

endpackage : sw_pkg

// File: rtl/debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
// One debounce channel: two-flop synchronizer, four-state debounce FSM with
// an agreement counter, and registered level / rise / fall outputs.
//
// Ports:
//   clk_pin   in  system clock
//   rst_n_pin in  asynchronous active-low reset
//   tick      in  one-cycle sample strobe shared by all channels
//   pin       in  raw, asynchronous pin level
//   db        out debounced level (1 in S_HI and S_WAIT_LO)
//   rise      out one-cycle pulse on the S_WAIT_HI -> S_HI transition
//   fall      out one-cycle pulse on the S_WAIT_LO -> S_LO transition
// ---------------------------------------------------------------------------
module debounce_bit
    import sw_pkg::*;
#(
    parameter int STABLE_TICKS = DB_MS
) (
    input  logic clk_pin,
    input  logic rst_n_pin,
    input  logic tick,
    input  logic pin,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic      sync1_reg;
    logic      sync2_reg;
    db_state_t state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic      db_reg, db_next;
    logic      rise_reg, rise_next;
    logic      fall_reg, fall_next;

    always_ff @(posedge clk_pin or negedge rst_n_pin) begin
        if (!rst_n_pin) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            state_reg <= S_LO;
            cnt_reg   <= '0;
            db_reg    <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync1_reg <= pin;
            sync2_reg <= sync1_reg;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            db_reg    <= db_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    // The FSM only moves on tick cycles; the synchronized level is ignored
    // in between, so sub-tick glitches never reach the counter.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (tick) begin
            case (state_reg)
                S_LO: begin
                    if (sync2_reg) begin
                        state_next = S_WAIT_HI;
                        cnt_next   = CNT_ONE;
                    end
                end
                S_WAIT_HI: begin
                    if (!sync2_reg) begin
                        state_next = S_LO;
                        cnt_next   = '0;
                    end else if (cnt_reg == STABLE_C) begin
                        state_next = S_HI;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                S_HI: begin
                    if (!sync2_reg) begin
                        state_next = S_WAIT_LO;
                        cnt_next   = CNT_ONE;
                    end
                end
                S_WAIT_LO: begin
                    if (sync2_reg) begin
                        state_next = S_HI;
                        cnt_next   = '0;
                    end else if (cnt_reg == STABLE_C) begin
                        state_next = S_LO;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_next = S_LO;
                    cnt_next   = '0;
                end
            endcase
        end

        // Outputs are registered from the next state so the level and its
        // edge pulse appear in the same cycle the FSM settles.
        db_next   = (state_next == S_HI) || (state_next == S_WAIT_LO);
        rise_next = (state_reg == S_WAIT_HI) && (state_next == S_HI);
        fall_next = (state_reg == S_WAIT_LO) && (state_next == S_LO);
    end

    assign db   = db_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule : debounce_bit

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
// Debounces WIDTH raw switch/button pins. A free-running prescaler produces
// a one-cycle sample tick every TICK_DIV clocks; each channel accepts a new
// level only after STABLE_TICKS further agreeing ticks.
//
// Ports:
//   clk_pin   in  system clock (100 MHz on EGO1)
//   rst_n_pin in  asynchronous active-low reset
//   sw_pin    in  [WIDTH] raw pin levels, asynchronous to clk_pin
//   sw_db     out [WIDTH] debounced levels
//   sw_rise   out [WIDTH] one-cycle pulse when sw_db[i] goes 0->1
//   sw_fall   out [WIDTH] one-cycle pulse when sw_db[i] goes 1->0
//   sw_any    out OR of all rise/fall pulses
// ---------------------------------------------------------------------------
module sw_debounce
    import sw_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int TICK_DIV     = TICK_DIV_1MS,
    parameter int STABLE_TICKS = DB_MS
) (
    input  logic             clk_pin,
    input  logic             rst_n_pin,
    input  logic [WIDTH-1:0] sw_pin,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_any
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
    logic          tick;

    always_ff @(posedge clk_pin or negedge rst_n_pin) begin
        if (!rst_n_pin) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_next;
        end
    end

    assign tick          = (tick_cnt_reg == TICK_LAST);
    assign tick_cnt_next = tick ? '0 : tick_cnt_reg + TICK_ONE;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            debounce_bit #(
                .STABLE_TICKS(STABLE_TICKS)
            ) u_bit (
                .clk_pin  (clk_pin),
                .rst_n_pin(rst_n_pin),
                .tick     (tick),
                .pin      (sw_pin[gi]),
                .db       (sw_db[gi]),
                .rise     (sw_rise[gi]),
                .fall     (sw_fall[gi])
            );
        end
    endgenerate

    assign sw_any = |(sw_rise | sw_fall);

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce
// Self-checking bench for sw_debounce with TICK_DIV=4, STABLE_TICKS=3.
// A table of pin steps with expected pulse masks and levels is applied in a
// loop; expected results go through a scoreboard queue. Hand-written
// sequences cover bouncing, reset mid-debounce and a pin held through reset.
// ---------------------------------------------------------------------------
module tb_sw_debounce;

    localparam int WIDTH    = 8;
    localparam int TDIV     = 4;
    localparam int STABLE   = 3;
    // A clean step becomes visible between 15 and 18 sampling negedges after
    // it is driven: 2 sync edges, 0..3 edges to the next tick, 3 more ticks.
    localparam int LAT_MIN  = 15;
    localparam int LAT_MAX  = 18;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] sw_pin;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_any;

    sw_debounce #(
        .WIDTH       (WIDTH),
        .TICK_DIV    (TDIV),
        .STABLE_TICKS(STABLE)
    ) dut (
        .clk_pin  (clk),
        .rst_n_pin(rst_n),
        .sw_pin   (sw_pin),
        .sw_db    (sw_db),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .sw_any   (sw_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pin;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] db;
        int         window;
    } vec_t;

    typedef struct {
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] db;
    } exp_t;

    vec_t vecs[9];
    exp_t sb_q[$];

    int vec_count  = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vec_count++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Drive one pin pattern and wait for the resulting pulse (or its absence).
    task automatic apply_vec(input vec_t v, input int idx);
        exp_t e;
        int   lat;
        bit   seen;
        logic [7:0] r_obs, f_obs, d_obs;
        sw_pin = v.pin;
        sb_q.push_back('{v.rise, v.fall, v.db});
        seen  = 1'b0;
        lat   = 0;
        r_obs = '0;
        f_obs = '0;
        d_obs = '0;
        for (int c = 1; c <= v.window && !seen; c++) begin
            @(negedge clk);
            if (sw_any) begin
                seen  = 1'b1;
                lat   = c;
                r_obs = sw_rise;
                f_obs = sw_fall;
                d_obs = sw_db;
            end
        end
        e = sb_q.pop_front();
        if ((e.rise | e.fall) != 8'h00) begin
            check($sformatf("v%0d_pulse_seen", idx), 32'(seen), 32'd1);
            if (seen) begin
                check($sformatf("v%0d_rise", idx), 32'(r_obs), 32'(e.rise));
                check($sformatf("v%0d_fall", idx), 32'(f_obs), 32'(e.fall));
                check($sformatf("v%0d_db", idx), 32'(d_obs), 32'(e.db));
                check($sformatf("v%0d_latency_in_range", idx),
                      32'((lat >= LAT_MIN) && (lat <= LAT_MAX)), 32'd1);
                @(negedge clk);
                check($sformatf("v%0d_any_one_cycle", idx), 32'(sw_any), 32'd0);
                check($sformatf("v%0d_db_hold", idx), 32'(sw_db), 32'(e.db));
            end
        end else begin
            check($sformatf("v%0d_no_pulse", idx), 32'(seen), 32'd0);
            check($sformatf("v%0d_db", idx), 32'(sw_db), 32'(e.db));
        end
    endtask

    initial begin
        int   pulses;
        int   db_bad;
        int   first_lat;
        logic [7:0] first_rise;
        exp_t e;

        vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 100};
        vecs[1] = '{8'h01, 8'h01, 8'h00, 8'h01, 40};
        vecs[2] = '{8'h00, 8'h00, 8'h01, 8'h00, 40};
        vecs[3] = '{8'hA5, 8'hA5, 8'h00, 8'hA5, 40};
        vecs[4] = '{8'hA4, 8'h00, 8'h01, 8'hA4, 40};
        vecs[5] = '{8'h5B, 8'h5B, 8'hA4, 8'h5B, 40};
        vecs[6] = '{8'h00, 8'h00, 8'h5B, 8'h00, 40};
        vecs[7] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 40};
        vecs[8] = '{8'h00, 8'h00, 8'hFF, 8'h00, 40};

        rst_n  = 1'b0;
        sw_pin = '0;
        repeat (3) @(negedge clk);
        check("reset_db",   32'(sw_db),   32'h0);
        check("reset_rise", 32'(sw_rise), 32'h0);
        check("reset_fall", 32'(sw_fall), 32'h0);
        check("reset_any",  32'(sw_any),  32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply_vec(vecs[i], i);
        end

        // Bounce on channel 1: each level held 5 cycles (< 2 ticks).
        pulses = 0;
        db_bad = 0;
        for (int ph = 0; ph < 4; ph++) begin
            sw_pin = (ph % 2 == 0) ? 8'h02 : 8'h00;
            for (int c = 0; c < ((ph == 3) ? 40 : 5); c++) begin
                @(negedge clk);
                if (sw_any) pulses++;
                if (sw_db[1]) db_bad++;
            end
        end
        check("bounce_pulses",  32'(pulses), 32'd0);
        check("bounce_db_high", 32'(db_bad), 32'd0);

        // Reset while channel 3 is high and starting to fall.
        apply_vec('{8'h08, 8'h08, 8'h00, 8'h08, 40}, 100);
        sw_pin = 8'h00;
        pulses = 0;
        repeat (TDIV) begin
            @(negedge clk);
            if (sw_any) pulses++;
        end
        check("pre_reset_no_fall", 32'(pulses), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_db",   32'(sw_db),   32'h0);
        check("midreset_fall", 32'(sw_fall), 32'h0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        db_bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (sw_any) pulses++;
            if (sw_db != 8'h00) db_bad++;
        end
        check("post_reset_pulses", 32'(pulses), 32'd0);
        check("post_reset_db_set", 32'(db_bad), 32'd0);

        // Channel 4 held high through reset release.
        rst_n  = 1'b0;
        sw_pin = 8'h10;
        repeat (3) @(negedge clk);
        check("held_reset_db", 32'(sw_db), 32'h0);
        sb_q.push_back('{8'h10, 8'h00, 8'h10});
        rst_n      = 1'b1;
        pulses     = 0;
        first_lat  = 0;
        first_rise = '0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (sw_any) begin
                pulses++;
                if (pulses == 1) begin
                    first_lat  = c;
                    first_rise = sw_rise;
                end
            end
        end
        e = sb_q.pop_front();
        check("held_pulse_count", 32'(pulses), 32'd1);
        check("held_rise", 32'(first_rise), 32'(e.rise));
        check("held_latency_in_range",
              32'((first_lat >= LAT_MIN) && (first_lat <= LAT_MAX)), 32'd1);
        check("held_db", 32'(sw_db), 32'(e.db));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule : tb_sw_debounce

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-side conditioning block for the EGO1 slide switches and push buttons.
- Raw, asynchronous, bouncing pin levels go in. Clean, synchronous, debounced levels come out, plus one-cycle rise and fall pulses.
- It drives the sw_pin inputs of the board's combinational examples and provides edge events for sequential designs.
- It sits directly after the top-level switch and button pins.

Parameters:
- WIDTH, 8, number of independent input channels.
- TICK_DIV, 100000, clk_pin cycles per sample tick (1 ms at 100 MHz). Must be ≥ 2.
- STABLE_TICKS, 20, consecutive agreeing sample ticks needed to accept a new level. Must be ≥ 1.

Ports:
- clk_pin, input, 1, system clock (100 MHz on EGO1).
- rst_n_pin, input, 1, reset; asynchronous assert, active-low.
- sw_pin, input, WIDTH, raw switch/button levels; asynchronous to clk_pin.
- sw_db, output, WIDTH, debounced level per channel.
- sw_rise, output, WIDTH, one-cycle pulse when sw_db[i] goes 0→1.
- sw_fall, output, WIDTH, one-cycle pulse when sw_db[i] goes 1→0.
- sw_any, output, 1, OR-reduction of (sw_rise | sw_fall); combinational from registered pulses.

Behaviour:
- Reset (rst_n_pin=0, asynchronous):
  - Synchronizer flops, tick counter, per-channel counters, sw_db, sw_rise and sw_fall all go to 0.
  - Every channel FSM goes to S_LO.
  - Deassertion takes effect on the next clk_pin edge.
- Synchronizer:
  - Two flops per channel; the synchronized value is sync[i].
  - Pin-to-sync latency is 2 cycles.
- Tick prescaler:
  - One counter, shared by all channels, runs 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly one cycle when count==TICK_DIV-1.
  - It runs freely from reset release and never stalls.
- Per-channel FSM, evaluated only on tick cycles:
  - States are S_LO, S_WAIT_HI, S_HI, S_WAIT_LO; each channel has a counter cnt of width clog2(STABLE_TICKS+1).
  - S_LO: if sync=1, go to S_WAIT_HI with cnt=1. Otherwise stay.
  - S_WAIT_HI: if sync=0, return to S_LO with cnt=0 (bounce rejected). If sync=1 and cnt==STABLE_TICKS, go to S_HI. Otherwise cnt+1.
  - S_HI and S_WAIT_LO mirror S_LO and S_WAIT_HI with polarity inverted.
  - When STABLE_TICKS=1, the S_WAIT_* state exits on the very next tick if the level still agrees.
- Outputs:
  - sw_db[i] is registered and equals 1 in S_HI and S_WAIT_LO, 0 in S_LO and S_WAIT_HI.
  - sw_rise[i] is 1 exactly in the cycle sw_db[i] first reads 1 (S_WAIT_HI→S_HI).
  - sw_fall[i] is the mirror of sw_rise[i].
  - A channel never asserts sw_rise and sw_fall in the same cycle.
  - Consecutive pulses on one channel are separated by at least STABLE_TICKS*TICK_DIV cycles.
- Latency:
  - Measured from a clean pin step to the sw_db change: 2 sync cycles, plus the wait for the next tick, plus STABLE_TICKS further ticks, plus 1 register cycle.
  - Bound: ≤ 3 + (STABLE_TICKS+1)*TICK_DIV cycles.
- Boundary conditions:
  - Pin changes between ticks are invisible; only tick samples count.
  - A bounce that reverts before cnt reaches STABLE_TICKS produces no pulse and leaves sw_db unchanged.
  - Channels are fully independent. Several channels may pulse in the same cycle; sw_any is then 1 once.
  - A pin held at 1 through reset release is debounced like any other change, so sw_rise fires once after the latency above.
  - Reset during S_WAIT_* discards all progress with no pulse. If sw_db was 1, it drops to 0 with no sw_fall.

Decomposition:
- Shared package sw_pkg holds the state enum (S_LO, S_WAIT_HI, S_HI, S_WAIT_LO) and default constants SYS_CLK_HZ=100_000_000 and DB_MS=20.
- Sub-module debounce_bit covers one channel: synchronizer, FSM, cnt, level and pulse registers. Inputs are clk_pin, rst_n_pin, tick and the raw pin.
- Top level: the tick prescaler, a generate loop of WIDTH instances, and the sw_any reduction.

Test Plan (TICK_DIV=4, STABLE_TICKS=3, WIDTH=8):
- Reset then idle, sw_pin=0x00 → sw_db=0x00, no pulses for 100 cycles.
- Clean step of sw_pin[0] from 0 to 1 → sw_rise[0] is a single 1-cycle pulse and sw_db[0]=1 within 3+16 cycles. No other bits change.
- sw_pin[1] bounces 1,0,1,0 with every state held shorter than 2 ticks, then stays 0 → no pulse, sw_db[1]=0 throughout.
- sw_pin goes 0x00→0xA5 in one cycle → rise pulses on bits 0, 2, 5, 7 in the same cycle, sw_any high for exactly 1 cycle, sw_db=0xA5.
- With sw_db[3]=1, drop sw_pin[3] to 0 and assert rst_n_pin=0 after 1 tick → sw_db=0x00 immediately, no sw_fall. After release with the pin still 0, no pulses occur.
- sw_pin[4]=1 held during reset, then release → exactly one sw_rise[4] pulse within 3+16 cycles of release.
